// File: rtl/config_loader.sv
// Serial bitstream configuration loader: sync, frame count, addr/data frames.
// Optional CRC-8 trailer check enabled by defining CONFIG_CRC_EN.
module config_loader #(
    parameter logic [7:0] SYNC_WORD    = 8'hA5,
    parameter int         NUM_TILES    = 24,
    parameter int         NUM_SWITCHES = 9
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        cfg_restart,
    output logic [5:0]  cfg_addr,
    output logic [32:0] cfg_data,
    output logic        cfg_we,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_COUNT,
        S_ADDR,
        S_DATA,
`ifdef CONFIG_CRC_EN
        S_CRC,
`endif
        S_DONE,
        S_ERROR
    } state_t;

`ifdef CONFIG_CRC_EN
    localparam state_t FIN_ST = S_CRC;
`else
    localparam state_t FIN_ST = S_DONE;
`endif

    localparam logic [6:0] TILE_END = 7'(NUM_TILES);
    localparam logic [6:0] SW_END   = 7'(32 + NUM_SWITCHES);

    state_t      state;
    logic [7:0]  window;
    logic [5:0]  bit_cnt;
    logic [7:0]  frame_cnt;
    logic [7:0]  n_frames;
    logic [5:0]  addr_sr;
    logic [31:0] data_sr;

    logic [7:0]  win_nx;
    logic [7:0]  cnt_nx;
    logic [5:0]  addr_nx;
    logic [32:0] data_nx;
    logic        addr_ok;
    logic        sw_bad;
    logic        last_frame;

    assign win_nx  = {window[6:0], bit_in};
    assign cnt_nx  = {n_frames[6:0], bit_in};
    assign addr_nx = {addr_sr[4:0], bit_in};
    assign data_nx = {data_sr, bit_in};

    // Tile range 0..NUM_TILES-1, switch range 32..32+NUM_SWITCHES-1
    assign addr_ok = ({1'b0, addr_nx} < TILE_END) ||
                     (addr_nx[5] && ({1'b0, addr_nx} < SW_END));
    assign sw_bad     = addr_sr[5] && (|data_nx[32:16]);
    assign last_frame = (frame_cnt == (n_frames - 8'd1));

`ifdef CONFIG_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_nx;
    assign crc_nx = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_in}} & 8'h07);
    assign cfg_busy = (state == S_COUNT) || (state == S_ADDR) ||
                      (state == S_DATA) || (state == S_CRC);
`else
    assign cfg_busy = (state == S_COUNT) || (state == S_ADDR) ||
                      (state == S_DATA);
`endif

    assign cfg_done  = (state == S_DONE);
    assign cfg_error = (state == S_ERROR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_SYNC;
            window    <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            n_frames  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
`ifdef CONFIG_CRC_EN
            crc       <= '0;
`endif
        end else begin
            cfg_we <= 1'b0;
            unique case (state)
                S_SYNC: begin
                    if (bit_valid) begin
                        window <= win_nx;
                        if (win_nx == SYNC_WORD) begin
                            window  <= '0;
                            bit_cnt <= '0;
                            state   <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (bit_valid) begin
                        n_frames <= cnt_nx;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt   <= '0;
                            frame_cnt <= '0;
`ifdef CONFIG_CRC_EN
                            crc       <= '0;
`endif
                            state <= (cnt_nx == 8'd0) ? FIN_ST : S_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (bit_valid) begin
                        addr_sr <= addr_nx;
`ifdef CONFIG_CRC_EN
                        crc     <= crc_nx;
`endif
                        if (bit_cnt == 6'd5) begin
                            bit_cnt <= '0;
                            state   <= addr_ok ? S_DATA : S_ERROR;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_valid) begin
                        data_sr <= data_nx[31:0];
`ifdef CONFIG_CRC_EN
                        crc     <= crc_nx;
`endif
                        if (bit_cnt == 6'd32) begin
                            bit_cnt <= '0;
                            if (sw_bad) begin
                                state <= S_ERROR;
                            end else begin
                                cfg_we    <= 1'b1;
                                cfg_addr  <= addr_sr;
                                cfg_data  <= data_nx;
                                frame_cnt <= frame_cnt + 8'd1;
                                state <= last_frame ? FIN_ST : S_ADDR;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
`ifdef CONFIG_CRC_EN
                // Received CRC shifts through the idle sync window
                S_CRC: begin
                    if (bit_valid) begin
                        window <= win_nx;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            window  <= '0;
                            state   <= (win_nx == crc) ? S_DONE : S_ERROR;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    if (cfg_restart) begin
                        state   <= S_SYNC;
                        window  <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule
